// File: rtl/regfile_pkg.sv
// Shared defaults and helpers for the multi-port register file.
package regfile_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned NREGS_DEF  = 16;
    localparam int unsigned ADDR_W_DEF = 4;
    localparam int unsigned SP_IDX_DEF = 14;
    localparam logic [31:0] SP_RST_DEF = 32'h0000_1000;

    // Widest packed read-address bus the slice helper accepts.
    localparam int unsigned ADDR_VEC_MAX = 256;

    // Returns port k's address field from a packed address bus (zero-extended to 32 bits).
    function automatic logic [31:0] port_addr(input logic [ADDR_VEC_MAX-1:0] vec,
                                              input int unsigned k,
                                              input int unsigned addr_w);
        logic [ADDR_VEC_MAX-1:0] w_sh;
        logic [31:0]             w_mask;
        w_sh   = vec >> (k * addr_w);
        w_mask = (32'd1 << addr_w) - 32'd1;
        return w_sh[31:0] & w_mask;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard: set on alloc (issue), cleared on writeback.
module regfile_scoreboard #(
    parameter int unsigned NREGS   = 16,
    parameter int unsigned ADDR_W  = 4,
    parameter bit          ZERO_R0 = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              alloc_en,
    input  logic [ADDR_W-1:0] alloc_addr,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    output logic [NREGS-1:0]  busy_vec,
    output logic [NREGS-1:0]  busy_next
);

    logic [NREGS-1:0] r_busy;

    // Next state: a same-cycle alloc beats the writeback clear (new producer supersedes).
    always_comb begin
        busy_next = '0;
        for (int i = 0; i < NREGS; i++) begin
            busy_next[i] = (alloc_en && (alloc_addr == ADDR_W'(i))) ||
                           (r_busy[i] && !(wb_en && (wb_addr == ADDR_W'(i))));
        end
        if (ZERO_R0) begin
            busy_next[0] = 1'b0;
        end
    end

    // Scoreboard state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_busy <= '0;
        end else begin
            r_busy <= busy_next;
        end
    end

    assign busy_vec = r_busy;

endmodule

// File: rtl/regfile_mp_scoreboard.sv
// Multi-port register file with registered reads, write-first bypass and busy scoreboard.
module regfile_mp_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned       DATA_W  = DATA_W_DEF,
    parameter int unsigned       NREGS   = NREGS_DEF,
    parameter int unsigned       ADDR_W  = ADDR_W_DEF,
    parameter int unsigned       NRD     = 2,
    parameter int unsigned       SP_IDX  = SP_IDX_DEF,
    parameter logic [DATA_W-1:0] SP_RST  = DATA_W'(SP_RST_DEF),
    parameter bit                ZERO_R0 = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NRD-1:0]        rd_en,
    input  logic [NRD*ADDR_W-1:0] rd_addr,
    output logic [NRD*DATA_W-1:0] rd_data,
    output logic [NRD-1:0]        rd_busy,
    input  logic                  wb_en,
    input  logic [ADDR_W-1:0]     wb_addr,
    input  logic [DATA_W-1:0]     wb_data,
    input  logic                  alloc_en,
    input  logic [ADDR_W-1:0]     alloc_addr,
    output logic [NREGS-1:0]      busy_vec
);

    logic [DATA_W-1:0] r_mem [NREGS];
    logic [NREGS-1:0]  w_busy_next;
    logic              w_wr_ok;

    regfile_scoreboard #(
        .NREGS   (NREGS),
        .ADDR_W  (ADDR_W),
        .ZERO_R0 (ZERO_R0)
    ) u_scoreboard (
        .clk        (clk),
        .reset      (reset),
        .alloc_en   (alloc_en),
        .alloc_addr (alloc_addr),
        .wb_en      (wb_en),
        .wb_addr    (wb_addr),
        .busy_vec   (busy_vec),
        .busy_next  (w_busy_next)
    );

    // Writes to r0 are dropped when r0 is hardwired to zero.
    assign w_wr_ok = wb_en && !(ZERO_R0 && (wb_addr == '0));

    // Storage array; the stack pointer has its own reset value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                r_mem[i] <= (i == SP_IDX) ? SP_RST : '0;
            end
        end else if (w_wr_ok) begin
            r_mem[wb_addr] <= wb_data;
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [ADDR_W-1:0] w_addr;
        logic [DATA_W-1:0] w_rd_val;
        logic [DATA_W-1:0] r_rd_data;
        logic              r_rd_busy;

        assign w_addr = ADDR_W'(port_addr(ADDR_VEC_MAX'(rd_addr), k, ADDR_W));

        // Write-first bypass; hardwired r0 overrides everything.
        always_comb begin
            w_rd_val = r_mem[w_addr];
            if (wb_en && (wb_addr == w_addr)) begin
                w_rd_val = wb_data;
            end
            if (ZERO_R0 && (w_addr == '0)) begin
                w_rd_val = '0;
            end
        end

        // Read register; busy is sampled from the scoreboard's next state to match the data.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_rd_data <= '0;
                r_rd_busy <= 1'b0;
            end else if (rd_en[k]) begin
                r_rd_data <= w_rd_val;
                r_rd_busy <= w_busy_next[w_addr];
            end
        end

        assign rd_data[k*DATA_W +: DATA_W] = r_rd_data;
        assign rd_busy[k]                  = r_rd_busy;
    end

endmodule

// File: tb/tb_regfile_mp_scoreboard.sv
// Directed self-checking bench: default configuration plus a 64x32, 3-port, zero-r0 variant.
module tb_regfile_mp_scoreboard;

    logic clk;
    logic reset;

    int checks;
    int errors;

    // Default-parameter DUT signals.
    logic [1:0]  a_rd_en;
    logic [7:0]  a_rd_addr;
    logic [63:0] a_rd_data;
    logic [1:0]  a_rd_busy;
    logic        a_wb_en;
    logic [3:0]  a_wb_addr;
    logic [31:0] a_wb_data;
    logic        a_alloc_en;
    logic [3:0]  a_alloc_addr;
    logic [15:0] a_busy_vec;

    // Variant DUT signals.
    logic [2:0]   b_rd_en;
    logic [14:0]  b_rd_addr;
    logic [191:0] b_rd_data;
    logic [2:0]   b_rd_busy;
    logic         b_wb_en;
    logic [4:0]   b_wb_addr;
    logic [63:0]  b_wb_data;
    logic         b_alloc_en;
    logic [4:0]   b_alloc_addr;
    logic [31:0]  b_busy_vec;

    regfile_mp_scoreboard u_dut_a (
        .clk        (clk),
        .reset      (reset),
        .rd_en      (a_rd_en),
        .rd_addr    (a_rd_addr),
        .rd_data    (a_rd_data),
        .rd_busy    (a_rd_busy),
        .wb_en      (a_wb_en),
        .wb_addr    (a_wb_addr),
        .wb_data    (a_wb_data),
        .alloc_en   (a_alloc_en),
        .alloc_addr (a_alloc_addr),
        .busy_vec   (a_busy_vec)
    );

    regfile_mp_scoreboard #(
        .DATA_W  (64),
        .NREGS   (32),
        .ADDR_W  (5),
        .NRD     (3),
        .ZERO_R0 (1'b1)
    ) u_dut_b (
        .clk        (clk),
        .reset      (reset),
        .rd_en      (b_rd_en),
        .rd_addr    (b_rd_addr),
        .rd_data    (b_rd_data),
        .rd_busy    (b_rd_busy),
        .wb_en      (b_wb_en),
        .wb_addr    (b_wb_addr),
        .wb_data    (b_wb_data),
        .alloc_en   (b_alloc_en),
        .alloc_addr (b_alloc_addr),
        .busy_vec   (b_busy_vec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_a();
        a_rd_en    = '0;
        a_wb_en    = 1'b0;
        a_alloc_en = 1'b0;
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        reset        = 1'b1;
        a_rd_addr    = '0;
        a_wb_addr    = '0;
        a_wb_data    = '0;
        a_alloc_addr = '0;
        idle_a();
        b_rd_en      = '0;
        b_rd_addr    = '0;
        b_wb_en      = 1'b0;
        b_wb_addr    = '0;
        b_wb_data    = '0;
        b_alloc_en   = 1'b0;
        b_alloc_addr = '0;

        step();
        step();
        reset = 1'b0;

        // Dirty some state before the mid-cycle reset: wb r3, alloc r2, bypass-read r3.
        a_wb_en = 1'b1; a_wb_addr = 4'd3; a_wb_data = 32'h0000_00AA;
        a_alloc_en = 1'b1; a_alloc_addr = 4'd2;
        a_rd_en = 2'b01; a_rd_addr = {4'd0, 4'd3};
        step();
        idle_a();
        chk("pre_reset_rd0", a_rd_data[31:0], 64'h0000_00AA);
        chk("pre_reset_busy", a_busy_vec, 64'h0004);

        // Asynchronous reset between clock edges.
        #3;
        reset = 1'b1;
        #1;
        chk("async_rst_rd0", a_rd_data[31:0], 64'h0);
        chk("async_rst_busy_vec", a_busy_vec, 64'h0);
        step();
        reset = 1'b0;

        // Read SP (r14) on port 0 and r3 on port 1.
        a_rd_en = 2'b11; a_rd_addr = {4'd3, 4'd14};
        step();
        idle_a();
        chk("rst_sp_rd0", a_rd_data[31:0], 64'h0000_1000);
        chk("rst_r3_rd1", a_rd_data[63:32], 64'h0);
        chk("rst_rd_busy", a_rd_busy, 64'h0);
        chk("rst_busy_vec", a_busy_vec, 64'h0);

        // Write r5, then read it the next cycle on port 1.
        a_wb_en = 1'b1; a_wb_addr = 4'd5; a_wb_data = 32'hDEAD_BEEF;
        step();
        idle_a();
        a_rd_en = 2'b10; a_rd_addr = {4'd5, 4'd0};
        step();
        idle_a();
        chk("wr_rd_r5", a_rd_data[63:32], 64'hDEAD_BEEF);
        chk("wr_no_busy", a_busy_vec, 64'h0);
        // rd_en low: port 1 holds although r5 and its address change.
        a_wb_en = 1'b1; a_wb_addr = 4'd5; a_wb_data = 32'h0000_0001;
        a_rd_addr = {4'd3, 4'd3};
        step();
        idle_a();
        chk("hold_rd1", a_rd_data[63:32], 64'hDEAD_BEEF);

        // Same-cycle bypass on both ports.
        a_wb_en = 1'b1; a_wb_addr = 4'd7; a_wb_data = 32'h1234_5678;
        a_rd_en = 2'b11; a_rd_addr = {4'd7, 4'd7};
        step();
        idle_a();
        chk("bypass_rd0", a_rd_data[31:0], 64'h1234_5678);
        chk("bypass_rd1", a_rd_data[63:32], 64'h1234_5678);

        // Scoreboard lifecycle on r9.
        a_alloc_en = 1'b1; a_alloc_addr = 4'd9;
        step();
        idle_a();
        chk("sb_alloc_r9", a_busy_vec, 64'h0200);
        a_rd_en = 2'b01; a_rd_addr = {4'd0, 4'd9};
        step();
        idle_a();
        chk("sb_rd_busy1", a_rd_busy[0], 64'h1);
        chk("sb_rd_data0", a_rd_data[31:0], 64'h0);
        step();
        a_wb_en = 1'b1; a_wb_addr = 4'd9; a_wb_data = 32'h0000_0005;
        a_rd_en = 2'b01; a_rd_addr = {4'd0, 4'd9};
        step();
        idle_a();
        chk("sb_wb_rd_busy0", a_rd_busy[0], 64'h0);
        chk("sb_wb_rd_data", a_rd_data[31:0], 64'h5);
        chk("sb_wb_clear", a_busy_vec, 64'h0);

        // Alloc/wb collision on r4 with a same-cycle read on port 1.
        a_alloc_en = 1'b1; a_alloc_addr = 4'd4;
        step();
        idle_a();
        chk("coll_pre_busy", a_busy_vec, 64'h0010);
        a_alloc_en = 1'b1; a_alloc_addr = 4'd4;
        a_wb_en = 1'b1; a_wb_addr = 4'd4; a_wb_data = 32'h0000_0008;
        a_rd_en = 2'b10; a_rd_addr = {4'd4, 4'd0};
        step();
        idle_a();
        chk("coll_rd_data", a_rd_data[63:32], 64'h8);
        chk("coll_rd_busy", a_rd_busy[1], 64'h1);
        chk("coll_busy_vec", a_busy_vec, 64'h0010);
        a_rd_en = 2'b01; a_rd_addr = {4'd0, 4'd4};
        step();
        idle_a();
        chk("coll_stored", a_rd_data[31:0], 64'h8);
        chk("coll_port1_hold", a_rd_data[63:32], 64'h8);

        // Variant: r0 hardwired to zero, never busy.
        b_wb_en = 1'b1; b_wb_addr = 5'd0; b_wb_data = '1;
        b_alloc_en = 1'b1; b_alloc_addr = 5'd0;
        b_rd_en = 3'b111; b_rd_addr = {5'd0, 5'd0, 5'd0};
        step();
        chk("v_r0_rd0", b_rd_data[63:0], 64'h0);
        chk("v_r0_rd1", b_rd_data[127:64], 64'h0);
        chk("v_r0_rd2", b_rd_data[191:128], 64'h0);
        chk("v_r0_busy", b_rd_busy, 64'h0);
        chk("v_r0_busy_vec", b_busy_vec, 64'h0);

        // Variant: full-width bypass on r1 with alloc, r0 still 0, SP at reset value.
        b_wb_en = 1'b1; b_wb_addr = 5'd1; b_wb_data = 64'hFFFF_FFFF_FFFF_FFFF;
        b_alloc_en = 1'b1; b_alloc_addr = 5'd1;
        b_rd_en = 3'b111; b_rd_addr = {5'd14, 5'd1, 5'd0};
        step();
        b_wb_en = 1'b0; b_alloc_en = 1'b0; b_rd_en = '0;
        chk("v_r0_after", b_rd_data[63:0], 64'h0);
        chk("v_r1_bypass", b_rd_data[127:64], 64'hFFFF_FFFF_FFFF_FFFF);
        chk("v_sp_rd2", b_rd_data[191:128], 64'h0000_0000_0000_1000);
        chk("v_rd_busy", b_rd_busy, 64'h2);
        chk("v_busy_vec", b_busy_vec, 64'h0000_0002);

        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
